// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU main control FSM.
//   - opcode constants for the supported instruction set
//   - ALUOp encodings understood by the ALU controller
//   - FSM state encoding (also exported on state_o for debug)
//   - select encodings for the ALU B operand mux and the PC source mux
package multicycle_ctrl_pkg;

  // Opcodes, as found in IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp values; the ALU controller decodes exactly these
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_R   = 3'b010;
  localparam logic [2:0] ALUOP_SLT = 3'b011;

  // ALU B operand select
  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } state_t;

  // True for the states that wait on the unified memory handshake
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait timeout counter.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   clear    : synchronous clear (wins over count_en)
//   count_en : advance the count by one this cycle
//   expired  : count has reached MAX_WAIT
// The count saturates at MAX_WAIT so it can never wrap back into a
// "not expired" value if the owner keeps counting. WAIT_W must be wide
// enough to hold MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE   = WAIT_W'(1);

  logic [WAIT_W-1:0] count_r;

  assign expired = (count_r == LIMIT);

  // Wait-cycle counter: clear has priority, saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_en && !expired) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU datapath.
// Sequences fetch / decode / execute / memory / writeback and drives every
// mux select and write strobe, plus ALUOp for the ALU controller.
// Ports:
//   clk_i, rst_i (async, active-low)
//   op_i            opcode from the instruction register
//   mem_ready_i     memory finished the current access this cycle
//   pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
//   ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o   strobes / selects
//   alu_src_a_o, alu_src_b_o[1:0], alu_op_o[2:0], pc_source_o[1:0]
//   instr_done_o    pulse as an instruction retires
//   illegal_o       pulse on an unknown opcode (in DECODE)
//   mem_err_o       pulse when a memory wait times out
//   state_o[3:0]    current state, for debug
// Outputs are decoded from the state register; the fetch and memory states
// additionally gate their strobes with mem_ready_i. Because nothing is
// decoded from anything but state and live inputs, an asserted reset
// forces IDLE and therefore all-zero outputs without waiting for a clock.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic       mem_err_o,
  output logic [3:0] state_o
);

  state_t state_r;
  state_t state_next_s;
  logic   in_wait_s;
  logic   expired_s;
  logic   count_en_s;
  logic   clear_s;

  // The counter only runs while stalled in a wait state. Leaving a wait
  // state (ready) or retrying after a timeout restarts it, and every
  // non-wait state holds it at zero, so each wait state is entered with a
  // fresh count.
  assign in_wait_s  = is_wait_state(state_r);
  assign count_en_s = in_wait_s & ~mem_ready_i;
  assign clear_s    = ~in_wait_s | mem_ready_i | expired_s;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .clear    (clear_s),
    .count_en (count_en_s),
    .expired  (expired_s)
  );

  assign state_o = state_r;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next_s    = state_r;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = ALU_B_RT;
    alu_op_o        = ALUOP_ADD;
    pc_source_o     = PC_SRC_ALU;
    instr_done_o    = 1'b0;
    illegal_o       = 1'b0;
    mem_err_o       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        state_next_s = ST_FETCH;
      end

      ST_FETCH: begin
        // PC + 4 is computed by the ALU while the instruction is read
        mem_read_o  = 1'b1;
        alu_src_b_o = ALU_B_FOUR;
        if (mem_ready_i) begin
          ir_write_o   = 1'b1;
          pc_write_o   = 1'b1;
          state_next_s = ST_DECODE;
        end else if (expired_s) begin
          // PC was not written, so the retry fetches the same address
          mem_err_o    = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_FETCH;
        end
      end

      ST_DECODE: begin
        // Branch target is computed speculatively into ALUOut
        alu_src_b_o = ALU_B_IMM_SH2;
        case (op_i)
          OP_RTYPE: state_next_s = ST_EXEC_R;
          OP_ADDI:  state_next_s = ST_EXEC_I;
          OP_SLTI:  state_next_s = ST_EXEC_I;
          OP_LW:    state_next_s = ST_MEM_ADDR;
          OP_SW:    state_next_s = ST_MEM_ADDR;
          OP_BEQ:   state_next_s = ST_BRANCH;
          OP_J:     state_next_s = ST_JUMP;
          default: begin
            illegal_o    = 1'b1;
            state_next_s = ST_FETCH;
          end
        endcase
      end

      ST_EXEC_R: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALUOP_R;
        state_next_s = ST_WB_R;
      end

      ST_WB_R: begin
        reg_dst_o    = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_next_s = ST_FETCH;
      end

      ST_EXEC_I: begin
        // IR is not reloaded after fetch, so op_i still names this instruction
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_B_IMM;
        if (op_i == OP_SLTI) begin
          alu_op_o = ALUOP_SLT;
        end else begin
          alu_op_o = ALUOP_ADD;
        end
        state_next_s = ST_WB_I;
      end

      ST_WB_I: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_next_s = ST_FETCH;
      end

      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_B_IMM;
        if (op_i == OP_LW) begin
          state_next_s = ST_MEM_RD;
        end else begin
          state_next_s = ST_MEM_WR;
        end
      end

      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i) begin
          state_next_s = ST_WB_MEM;
        end else if (expired_s) begin
          // Load is dropped; no register write follows
          mem_err_o    = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_MEM_RD;
        end
      end

      ST_WB_MEM: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_next_s = ST_FETCH;
      end

      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_next_s = ST_FETCH;
        end else if (expired_s) begin
          mem_err_o    = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_MEM_WR;
        end
      end

      ST_BRANCH: begin
        // rs - rt sets zero; the datapath gates the PC write with it
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALUOP_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PC_SRC_ALUOUT;
        instr_done_o    = 1'b1;
        state_next_s    = ST_FETCH;
      end

      ST_JUMP: begin
        pc_write_o   = 1'b1;
        pc_source_o  = PC_SRC_JUMP;
        instr_done_o = 1'b1;
        state_next_s = ST_FETCH;
      end

      default: begin
        // Unused encodings recover through IDLE with all outputs low
        state_next_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle version of the CPU datapath.
- Decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the existing ALU controller's ALUOp input, plus all mux selects and write strobes.
- Handshakes with a variable-latency unified memory via mem_ready_i and bounds each wait with a timeout counter.

Parameters:
- MAX_WAIT, 15: maximum cycles spent in any memory-wait state before the access is aborted.
- WAIT_W, 4: width of the wait counter. Must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- op_i  input  6  opcode, taken from the instruction register output.
- mem_ready_i  input  1  memory completed the current read or write this cycle.
- pc_write_o  output  1  unconditional PC write.
- pc_write_cond_o  output  1  PC write when ALU zero is set (beq).
- i_or_d_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  output  1  memory read request.
- mem_write_o  output  1  memory write request.
- ir_write_o  output  1  instruction register load.
- mem_to_reg_o  output  1  writeback data select: 1 = MDR.
- reg_dst_o  output  1  destination register select: 1 = rd, 0 = rt.
- reg_write_o  output  1  register file write.
- alu_src_a_o  output  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b_o  output  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op_o  output  3  to the ALU controller: 000 add, 001 sub, 010 R-type (funct-decoded), 011 slt.
- pc_source_o  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done_o  output  1  one-cycle pulse as an instruction retires.
- illegal_o  output  1  one-cycle pulse on an unknown opcode.
- mem_err_o  output  1  one-cycle pulse on memory timeout.
- state_o  output  4  current state encoding, for debug.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_i = 0: state = IDLE, wait counter = 0, every output 0.
  - After release, IDLE → FETCH on the first rising edge.
  - A reset mid-instruction abandons it with no further strobes.
- Output style:
  - Moore outputs decoded from state.
  - Write strobes ir_write_o, pc_write_o and reg_write_o in the memory states are additionally gated by mem_ready_i, as stated per state below.
  - Any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - When mem_ready_i=1: ir_write=1 and pc_write=1 in the same cycle, then → DECODE.
  - Otherwise hold, with the strobes low.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state by op_i:
    - 000000 → EXEC_R
    - 001000 (addi) → EXEC_I
    - 001010 (slti) → EXEC_I
    - 100011 (lw) → MEM_ADDR
    - 101011 (sw) → MEM_ADDR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - any other opcode: illegal_o=1 this cycle, → FETCH, no register or memory write.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010 → WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=0, instr_done=1 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=000 for addi, 011 for slti (op_i is stable because the IR is not rewritten) → WB_I.
- WB_I: reg_dst=0, reg_write=1, mem_to_reg=0, instr_done=1 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 → MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - Drives mem_read=1, i_or_d=1.
  - When mem_ready_i=1 → WB_MEM.
- WB_MEM: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1 → FETCH.
- MEM_WR:
  - Drives mem_write=1, i_or_d=1.
  - When mem_ready_i=1: instr_done=1, → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, instr_done=1 → FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 → FETCH.
- Wait counter (FETCH, MEM_RD, MEM_WR only):
  - Cleared on entry to each wait state; increments each cycle with mem_ready_i=0.
  - If it equals MAX_WAIT while mem_ready_i=0: mem_err_o=1, → FETCH with the counter cleared, and no ir_write, pc_write or reg_write.
  - An aborted FETCH retries at the same PC; an aborted lw or sw is dropped.
  - mem_ready_i=1 arriving in the timeout cycle wins: the access completes normally and mem_err_o stays 0.
- Illegal opcode and timeout never occur in the same cycle.
- mem_ready_i outside the three wait states is ignored.

Decomposition:
- Shared package:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - ALUOp constants: ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_R=010, ALUOP_SLT=011. These must match the ALU controller's decode.
  - State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, MEM_ADDR=7, MEM_RD=8, WB_MEM=9, MEM_WR=10, BRANCH=11, JUMP=12.
  - Select encodings for alu_src_b_o and pc_source_o.
- Sub-module: the memory-wait timeout counter, mem_wait_timer (inputs: clear, count-enable; output: expired).

Test Plan:
- Reset release with mem_ready_i=1 and op_i=000000: IDLE → FETCH (mem_read=1, ir_write=1, pc_write=1) → DECODE → EXEC_R (alu_op=010) → WB_R (reg_write=1, reg_dst=1, instr_done=1) → FETCH; exactly 4 cycles from FETCH to retire.
- lw (100011) with mem_ready_i low for 3 cycles in MEM_RD: 4 cycles in MEM_RD, then WB_MEM with mem_to_reg=1 and reg_write=1; sw (101011) in MEM_WR: mem_write=1 until ready, then instr_done=1 and no reg_write.
- beq (000100): BRANCH cycle shows alu_op=001, pc_write_cond=1, pc_source=01; j (000010): pc_write=1, pc_source=10.
- op_i=111111 in DECODE: illegal_o pulses for 1 cycle, next state FETCH, reg_write and mem_write stay 0 throughout.
- FETCH with mem_ready_i held 0 (MAX_WAIT=15): mem_err_o pulses in the 16th FETCH cycle, ir_write and pc_write never assert, FETCH is re-entered; with ready rising exactly in that cycle, the fetch completes and mem_err_o=0.
- rst_i dropped asynchronously mid-MEM_WR: mem_write_o and all other outputs go 0 immediately without a clock edge, state_o=0; after release, fetch restarts.
